// File: rtl/force_gather64_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | force_gather64_pkg                                                    |
// | Shared constants, pass encodings, FSM state type and single-precision |
// | arithmetic helpers for the grid-to-particle force gather.             |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package force_gather64_pkg;

  localparam logic [31:0] FPONE = 32'h3F80_0000;

  // Pass encodings, shared with the coefficient generator
  localparam logic [1:0] COMP_CHARGE = 2'b00;
  localparam logic [1:0] COMP_X      = 2'b01;
  localparam logic [1:0] COMP_Y      = 2'b10;
  localparam logic [1:0] COMP_Z      = 2'b11;

  localparam int NUMEQU_DFLT   = 4;
  localparam int MULDELAY_DFLT = 3;
  localparam int ADDDELAY_DFLT = 2;

  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    WAIT_Z = 2'd2
  } gather_state_e;

  // Single-precision multiply, round-to-nearest-even; subnormals flush to zero,
  // overflow saturates to infinity.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic [23:0]        m;
    logic               g;
    logic               st;
    logic [24:0]        mr;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      m = mr[24:1];
      e = e + 11'sd1;
    end else begin
      m = mr[23:0];
    end
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Single-precision add with three guard bits, round-to-nearest-even.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [26:0]       lost;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic              found;
    logic [24:0]       mr;
    logic [23:0]       m;
    logic signed [9:0] e;
    if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? 32'h0 : b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    // x carries the larger magnitude and therefore the result sign
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      my = 27'd1;
    end else begin
      lost = my & ~(27'h7FF_FFFF << d);
      my   = (my >> d) | {26'd0, |lost};
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == 28'd0) return 32'h0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      found = 1'b0;
      lz    = 5'd0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && s[i]) begin
          found = 1'b1;
          lz    = 5'(26 - i);
        end
      end
      s = s << lz;
      e = e - $signed({5'd0, lz});
    end
    mr = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
    if (mr[24]) begin
      m = mr[24:1];
      e = e + 10'sd1;
    end else begin
      m = mr[23:0];
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return 32'h0;
    return {x[31], e[7:0], m[22:0]};
  endfunction

  // Force is the negated potential gradient; a zero magnitude always maps to +0.
  function automatic logic [31:0] fp_neg(input logic [31:0] v);
    return (v[30:0] == 31'd0) ? 32'h0 : {~v[31], v[30:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/force_gather64_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | force_gather64_if                                                     |
// | Pass input bus and force-vector output handshake of the gather block. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface force_gather64_if #(
  parameter int NUMEQU = 4,
  parameter int TAGW   = 16
);
  logic                                              valid_in;
  logic [1:0]                                        comp_in;
  logic [TAGW-1:0]                                   tag_in;
  logic [NUMEQU-1:0][NUMEQU-1:0][NUMEQU-1:0][31:0]  coeff;
  logic [NUMEQU-1:0][NUMEQU-1:0][NUMEQU-1:0][31:0]  grid_val;
  logic                                              force_ready;
  logic                                              force_valid;
  logic [31:0]                                       force_x;
  logic [31:0]                                       force_y;
  logic [31:0]                                       force_z;
  logic [TAGW-1:0]                                   tag_out;
  logic                                              seq_err;
  logic                                              ovf;

  modport master (
    output valid_in, comp_in, tag_in, coeff, grid_val, force_ready,
    input  force_valid, force_x, force_y, force_z, tag_out, seq_err, ovf
  );

  modport slave (
    input  valid_in, comp_in, tag_in, coeff, grid_val, force_ready,
    output force_valid, force_x, force_y, force_z, tag_out, seq_err, ovf
  );
endinterface
`default_nettype wire

// File: rtl/customdelay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | customdelay                                                           |
// | Fixed-length register delay line, cleared by synchronous reset.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module customdelay #(
  parameter int WIDTH = 32,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] pipe_q [DELAY];

  // shift the value one stage per clock; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DELAY-1];
endmodule
`default_nettype wire

// File: rtl/force_gather64_fp_dot64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | force_gather64_fp_dot64                                               |
// | 64-way FP dot product: parallel multipliers feeding a balanced adder  |
// | tree; fixed latency MULDELAY + log2(64)*ADDDELAY, never stalls.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module force_gather64_fp_dot64
  import force_gather64_pkg::*;
#(
  parameter int NUMEQU   = NUMEQU_DFLT,
  parameter int MULDELAY = MULDELAY_DFLT,
  parameter int ADDDELAY = ADDDELAY_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMEQU**3*32-1:0]    coeff_i,
  input  logic [NUMEQU**3*32-1:0]    grid_i,
  output logic [31:0]                sum_o
);
  localparam int N = NUMEQU**3;

  // Heap-ordered tree: node 0 is the root, leaves N-1..2N-2 are the products.
  // N is a power of two, so every leaf sits at the same depth and all
  // partial sums meet their partners in the same cycle.
  logic [31:0] node [2*N-1];

  generate
    for (genvar k = 0; k < N; k++) begin : g_mul
      logic [31:0] prod;
      assign prod = fp_mul(coeff_i[k*32 +: 32], grid_i[k*32 +: 32]);
      customdelay #(.WIDTH(32), .DELAY(MULDELAY)) u_mul_dly (
        .clk (clk),
        .rst (rst),
        .d_i (prod),
        .q_o (node[N-1+k])
      );
    end

    for (genvar i = 0; i < N-1; i++) begin : g_add
      logic [31:0] psum;
      assign psum = fp_add(node[2*i+1], node[2*i+2]);
      customdelay #(.WIDTH(32), .DELAY(ADDDELAY)) u_add_dly (
        .clk (clk),
        .rst (rst),
        .d_i (psum),
        .q_o (node[i])
      );
    end
  endgenerate

  assign sum_o = node[0];
endmodule
`default_nettype wire

// File: rtl/force_gather64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | force_gather64                                                        |
// | Grid-to-particle force gather: reduces X/Y/Z derivative passes to dot |
// | products, assembles them into a negated force vector and presents it  |
// | on a one-entry valid/ready output register.                           |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module force_gather64
  import force_gather64_pkg::*;
#(
  parameter int NUMEQU   = NUMEQU_DFLT,
  parameter int MULDELAY = MULDELAY_DFLT,
  parameter int ADDDELAY = ADDDELAY_DFLT,
  parameter int TAGW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  force_gather64_if.slave  bus
);
  localparam int LAT = MULDELAY + $clog2(NUMEQU**3) * ADDDELAY;

  logic [31:0]     sum;
  logic [TAGW+2:0] ctrl_in;
  logic [TAGW+2:0] ctrl_dly;
  logic            dly_valid;
  logic [1:0]      dly_comp;
  logic [TAGW-1:0] dly_tag;

  gather_state_e   state_q;
  logic [31:0]     sx_q;
  logic [31:0]     sy_q;
  logic [TAGW-1:0] tag_q;
  logic            force_valid_q;
  logic [31:0]     fx_q;
  logic [31:0]     fy_q;
  logic [31:0]     fz_q;
  logic [TAGW-1:0] tag_out_q;
  logic            seq_err_q;
  logic            ovf_q;

  force_gather64_fp_dot64 #(
    .NUMEQU   (NUMEQU),
    .MULDELAY (MULDELAY),
    .ADDDELAY (ADDDELAY)
  ) u_dot (
    .clk     (clk),
    .rst     (rst),
    .coeff_i (bus.coeff),
    .grid_i  (bus.grid_val),
    .sum_o   (sum)
  );

  // Charge-mapping passes are stripped here so they never reach the assembler.
  assign ctrl_in = {bus.valid_in && (bus.comp_in != COMP_CHARGE), bus.comp_in, bus.tag_in};

  customdelay #(.WIDTH(TAGW+3), .DELAY(LAT)) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .d_i (ctrl_in),
    .q_o (ctrl_dly)
  );

  assign {dly_valid, dly_comp, dly_tag} = ctrl_dly;

  // assembler FSM plus the one-entry output register it feeds
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_X;
      sx_q          <= '0;
      sy_q          <= '0;
      tag_q         <= '0;
      force_valid_q <= 1'b0;
      fx_q          <= '0;
      fy_q          <= '0;
      fz_q          <= '0;
      tag_out_q     <= '0;
      seq_err_q     <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      if (force_valid_q && bus.force_ready) force_valid_q <= 1'b0;
      if (dly_valid) begin
        unique case (state_q)
          WAIT_X: begin
            if (dly_comp == COMP_X) begin
              sx_q    <= sum;
              tag_q   <= dly_tag;
              state_q <= WAIT_Y;
            end else begin
              seq_err_q <= 1'b1;
            end
          end
          WAIT_Y: begin
            if (dly_comp == COMP_Y && dly_tag == tag_q) begin
              sy_q    <= sum;
              state_q <= WAIT_Z;
            end else if (dly_comp == COMP_X) begin
              // a fresh X abandons the partial triple and starts over
              seq_err_q <= 1'b1;
              sx_q      <= sum;
              tag_q     <= dly_tag;
            end else begin
              seq_err_q <= 1'b1;
              state_q   <= WAIT_X;
            end
          end
          WAIT_Z: begin
            if (dly_comp == COMP_Z && dly_tag == tag_q) begin
              state_q <= WAIT_X;
              if (!force_valid_q || bus.force_ready) begin
                fx_q          <= fp_neg(sx_q);
                fy_q          <= fp_neg(sy_q);
                fz_q          <= fp_neg(sum);
                tag_out_q     <= tag_q;
                force_valid_q <= 1'b1;
              end else begin
                // the held vector wins; the new one is lost
                ovf_q <= 1'b1;
              end
            end else if (dly_comp == COMP_X) begin
              seq_err_q <= 1'b1;
              sx_q      <= sum;
              tag_q     <= dly_tag;
              state_q   <= WAIT_Y;
            end else begin
              seq_err_q <= 1'b1;
              state_q   <= WAIT_X;
            end
          end
          default: state_q <= WAIT_X;
        endcase
      end
    end
  end

  assign bus.force_valid = force_valid_q;
  assign bus.force_x     = fx_q;
  assign bus.force_y     = fy_q;
  assign bus.force_z     = fz_q;
  assign bus.tag_out     = tag_out_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.ovf         = ovf_q;
endmodule
`default_nettype wire

// File: doc/force_gather64.md
Name: force_gather64

Overview:
- Back-interpolation (grid-to-particle) end of the long-range pipeline; the inverse of the charge-mapping coefficient path.
- For each particle it takes three derivative passes of 64 basis coefficients (d/dx, d/dy, d/dz), each paired with the 4x4x4 grid potentials read back from grid memory.
- Each pass is reduced to a dot product by a pipelined FP multiply/adder tree. The three results are assembled into one negated force vector and handed downstream on a valid/ready handshake.

Parameters:
- NUMEQU, 4, basis points per dimension (grid is NUMEQU^3 = 64 points).
- MULDELAY, 3, FpMul latency in cycles.
- ADDDELAY, 2, FpAdd latency in cycles.
- TAGW, 16, particle tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  one-cycle pulse: coeff and grid_val are valid this cycle.
- comp_in  in  2  pass select: 01 = X, 10 = Y, 11 = Z, 00 = charge-mapping pass (ignored).
- tag_in  in  TAGW  particle tag.
- coeff  in  32 x [NUMEQU][NUMEQU][NUMEQU]  IEEE-754 single coefficients, indexed [x][y][z].
- grid_val  in  32 x [NUMEQU][NUMEQU][NUMEQU]  IEEE-754 single grid potentials, same indexing.
- force_ready  in  1  downstream accepts the force vector.
- force_valid  out  1  force vector valid.
- force_x, force_y, force_z  out  32 each  IEEE-754 single force components.
- tag_out  out  TAGW  tag of the particle being output.
- seq_err  out  1  sticky sequence-error flag.
- ovf  out  1  sticky overflow (dropped result) flag.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: every output is 0. The FSM goes to WAIT_X, the control delay line is cleared, and in-flight data is discarded. No force_valid may appear from data accepted before rst deasserts.
- Datapath:
  - 64 parallel FpMul (coeff * grid_val).
  - 6-level FpAdd tree (64 -> 1).
  - Sum latency L = MULDELAY + 6*ADDDELAY = 15 cycles after valid_in.
  - Pipeline is fully pipelined and cannot stall; FP IP enable is tied to 1.
- Control shift register: carries {valid, comp, tag} alongside the datapath, delayed L cycles. valid_in with comp_in = 00 is dropped at entry.
- Assembler FSM, advanced on each delayed-valid result S:
  - WAIT_X:
    - comp = X: capture S as sx and capture the tag; go to WAIT_Y.
    - Otherwise: set seq_err; stay in WAIT_X.
  - WAIT_Y:
    - comp = Y and tag matches: capture sy; go to WAIT_Z.
    - comp = X: set seq_err; restart (capture the new X and tag); stay in WAIT_Y.
    - Otherwise: set seq_err; go to WAIT_X.
  - WAIT_Z:
    - comp = Z and tag matches: triple complete; go to WAIT_X.
    - comp = X: set seq_err; restart as above; go to WAIT_Y.
    - Otherwise: set seq_err; go to WAIT_X.
- Negation: force = -sum, implemented by flipping bit 31. If bits [30:0] are 0, output +0 (0x00000000).
- Output register (one entry), loaded on triple complete:
  - Register empty, or force_valid && force_ready in the same cycle: load it; force_valid = 1 the next cycle. Latency is L+1 = 16 cycles from the Z valid_in.
  - force_valid && !force_ready: the new triple is dropped, ovf is set, and the held entry is unchanged.
  - force_valid && force_ready with no new triple: clear force_valid.
- Outputs stay stable while force_valid && !force_ready.
- seq_err and ovf clear only on rst.
- Throughput: one pass per cycle, so one force vector per 3 cycles when passes stream back-to-back.

Decomposition:
- Shared package long_range_pkg:
  - FPONE.
  - Pass encodings COMP_CHARGE = 2'b00, COMP_X = 2'b01, COMP_Y = 2'b10, COMP_Z = 2'b11 (same encoding as the coefficient generator's CA_BI).
  - MULDELAY and ADDDELAY defaults.
  - FSM state enum.
- Sub-module fp_dot64: 64 FpMul plus adder tree, fixed latency L.
- Control delay reuses customdelay; the top level holds the FSM and output register.

Test Plan:
- Clean triple, force_ready = 1:
  - Stimulus: all coeff = 0x3F800000; grid_val = 0x3F000000 (X), 0x3E800000 (Y), 0x3F800000 (Z); tag 0x0005.
  - Response: at cycle 16 after the Z valid_in, force_valid = 1 with force_x = 0xC2000000, force_y = 0xC1800000, force_z = 0xC2800000, tag_out = 0x0005.
- Indexing:
  - Stimulus: only coeff[1][2][3] = 0x40000000 and grid_val[1][2][3] = 0x40400000, all others 0, on every pass.
  - Response: all components 0xC0C00000. A zero-sum pass gives 0x00000000.
- Sequence error:
  - Stimulus: X then Z for tag 1, then a clean triple for tag 2.
  - Response: seq_err = 1, no output for tag 1, correct output for tag 2; seq_err stays 1.
- Backpressure:
  - Stimulus: force_ready = 0; two complete triples.
  - Response: the first is held, ovf = 1, the second is dropped. Raising force_ready for one cycle pops the first; force_valid then drops.
- Streaming and pass 00:
  - Stimulus: passes X, Y, Z repeated every cycle for 4 particles, with COMP_CHARGE pulses interleaved; force_ready = 1.
  - Response: 4 outputs spaced 3 cycles apart (more if charge pulses intervene); charge pulses have no effect.
- Reset mid-flight:
  - Stimulus: assert rst 8 cycles after the Z valid_in.
  - Response: all outputs 0 and no force_valid for at least 20 cycles; a subsequent triple works normally.
